// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared widths, screen constants and game-state encoding for
//                the car, frog and collision blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

  // Coordinate widths for box edges
  localparam int X_W = 10;
  localparam int Y_W = 9;

  // Visible screen extent, shared with the car and frog position logic
  localparam int c_SCREEN_W = 640;
  localparam int c_SCREEN_H = 480;

  // Game-state encoding
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage : frogger_pkg
`default_nettype wire

// File: rtl/box_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : box_overlap
//  Description : Combinational strict-overlap test between two axis-aligned
//                boxes. Boxes that only share an edge do not overlap.
//  Revision    : 1.0 - initial release
// ============================================================================
module box_overlap
  import frogger_pkg::*;
(
  input  logic [X_W-1:0] a_l,
  input  logic [X_W-1:0] a_r,
  input  logic [Y_W-1:0] a_t,
  input  logic [Y_W-1:0] a_b,
  input  logic [X_W-1:0] b_l,
  input  logic [X_W-1:0] b_r,
  input  logic [Y_W-1:0] b_t,
  input  logic [Y_W-1:0] b_b,
  output logic           overlap
);

  // Unsigned, strict comparisons on both axes
  always_comb begin
    overlap = (b_l < a_r) && (a_l < b_r) && (b_t < a_b) && (a_t < b_b);
  end

endmodule : box_overlap
`default_nettype wire

// File: rtl/collision_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : collision_monitor
//  Description : Per-frame car/frog collision confirmation, lives and level
//                bookkeeping, post-hit freeze and game-over latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_monitor
  import frogger_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int CONFIRM     = 2,
  parameter int HOLD_FRAMES = 30,
  parameter int MAX_LEVEL   = 2
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           frame_tick,
  input  logic [X_W-1:0] carL,
  input  logic [X_W-1:0] carR,
  input  logic [Y_W-1:0] carT,
  input  logic [Y_W-1:0] carB,
  input  logic [X_W-1:0] frogL,
  input  logic [X_W-1:0] frogR,
  input  logic [Y_W-1:0] frogT,
  input  logic [Y_W-1:0] frogB,
  input  logic           frog_at_goal,
  output logic           hit,
  output logic           level_up,
  output logic           respawn,
  output logic [1:0]     lives,
  output logic [2:0]     level,
  output logic           game_over,
  output logic           frozen
);

  localparam logic [1:0] c_LIVES_INIT  = 2'(LIVES_INIT);
  localparam logic [2:0] c_CONFIRM     = 3'(CONFIRM);
  localparam logic [5:0] c_HOLD_FRAMES = 6'(HOLD_FRAMES);
  localparam logic [2:0] c_MAX_LEVEL   = 3'(MAX_LEVEL);

  state_t     r_state,     w_state_nx;
  logic [2:0] r_conf_cnt,  w_conf_cnt_nx;
  logic [5:0] r_hold_cnt,  w_hold_cnt_nx;
  logic [1:0] r_lives,     w_lives_nx;
  logic [2:0] r_level,     w_level_nx;
  logic       r_hit,       w_hit_nx;
  logic       r_level_up,  w_level_up_nx;
  logic       r_respawn,   w_respawn_nx;
  logic       r_game_over, w_game_over_nx;
  logic       r_frozen,    w_frozen_nx;

  logic       w_overlap;
  logic [2:0] w_conf_inc;
  logic [5:0] w_hold_inc;

  box_overlap u_overlap (
    .a_l     (carL),
    .a_r     (carR),
    .a_t     (carT),
    .a_b     (carB),
    .b_l     (frogL),
    .b_r     (frogR),
    .b_t     (frogT),
    .b_b     (frogB),
    .overlap (w_overlap)
  );

  assign w_conf_inc = r_conf_cnt + 3'd1;
  assign w_hold_inc = r_hold_cnt + 6'd1;

  // Next-state and next-output decode; only frame ticks advance the game
  always_comb begin
    w_state_nx    = r_state;
    w_conf_cnt_nx = r_conf_cnt;
    w_hold_cnt_nx = r_hold_cnt;
    w_lives_nx    = r_lives;
    w_level_nx    = r_level;
    w_hit_nx      = 1'b0;
    w_level_up_nx = 1'b0;
    w_respawn_nx  = 1'b0;

    if (frame_tick) begin
      case (r_state)
        PLAY: begin
          if (w_overlap && (w_conf_inc == c_CONFIRM)) begin
            // Confirmed hit outranks a simultaneous goal
            w_hit_nx      = 1'b1;
            w_conf_cnt_nx = 3'd0;
            w_hold_cnt_nx = 6'd0;
            if (r_lives <= 2'd1) begin
              w_lives_nx = 2'd0;
              w_state_nx = OVER;
            end else begin
              w_lives_nx = r_lives - 2'd1;
              w_state_nx = HOLD;
            end
          end else begin
            w_conf_cnt_nx = w_overlap ? w_conf_inc : 3'd0;
            if (frog_at_goal) begin
              // Goal discards any partial confirmation
              w_level_up_nx = 1'b1;
              w_respawn_nx  = 1'b1;
              w_conf_cnt_nx = 3'd0;
              if (r_level < c_MAX_LEVEL) begin
                w_level_nx = r_level + 3'd1;
              end
            end
          end
        end
        HOLD: begin
          w_hold_cnt_nx = w_hold_inc;
          if (w_hold_inc == c_HOLD_FRAMES) begin
            w_respawn_nx  = 1'b1;
            w_conf_cnt_nx = 3'd0;
            w_state_nx    = PLAY;
          end
        end
        OVER: begin
          w_state_nx = OVER;
        end
        default: begin
          w_state_nx = PLAY;
        end
      endcase
    end

    w_game_over_nx = (w_state_nx == OVER);
    w_frozen_nx    = (w_state_nx != PLAY);
  end

  // State, counter and registered-output update
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= PLAY;
      r_conf_cnt  <= 3'd0;
      r_hold_cnt  <= 6'd0;
      r_lives     <= c_LIVES_INIT;
      r_level     <= 3'd0;
      r_hit       <= 1'b0;
      r_level_up  <= 1'b0;
      r_respawn   <= 1'b0;
      r_game_over <= 1'b0;
      r_frozen    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_conf_cnt  <= w_conf_cnt_nx;
      r_hold_cnt  <= w_hold_cnt_nx;
      r_lives     <= w_lives_nx;
      r_level     <= w_level_nx;
      r_hit       <= w_hit_nx;
      r_level_up  <= w_level_up_nx;
      r_respawn   <= w_respawn_nx;
      r_game_over <= w_game_over_nx;
      r_frozen    <= w_frozen_nx;
    end
  end

  assign hit       = r_hit;
  assign level_up  = r_level_up;
  assign respawn   = r_respawn;
  assign lives     = r_lives;
  assign level     = r_level;
  assign game_over = r_game_over;
  assign frozen    = r_frozen;

endmodule : collision_monitor
`default_nettype wire

// File: tb/tb_collision_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_monitor
//  Description : Directed self-checking bench for collision_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_monitor;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       frame_tick;
  logic [9:0] carL, carR, frogL, frogR;
  logic [8:0] carT, carB, frogT, frogB;
  logic       frog_at_goal;
  logic       hit, level_up, respawn, game_over, frozen;
  logic [1:0] lives;
  logic [2:0] level;

  int n_checks = 0;
  int n_fails  = 0;
  int n_hit = 0, n_lvl = 0, n_rsp = 0;

  collision_monitor #(
    .LIVES_INIT  (3),
    .CONFIRM     (2),
    .HOLD_FRAMES (3),
    .MAX_LEVEL   (2)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .frame_tick   (frame_tick),
    .carL         (carL),
    .carR         (carR),
    .carT         (carT),
    .carB         (carB),
    .frogL        (frogL),
    .frogR        (frogR),
    .frogT        (frogT),
    .frogB        (frogB),
    .frog_at_goal (frog_at_goal),
    .hit          (hit),
    .level_up     (level_up),
    .respawn      (respawn),
    .lives        (lives),
    .level        (level),
    .game_over    (game_over),
    .frozen       (frozen)
  );

  always #5 clk_in = ~clk_in;

  // Single comparison point for every check
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick; outputs sampled 1 time unit after the sampling edge
  task automatic tick();
    @(negedge clk_in);
    frame_tick = 1'b1;
    @(posedge clk_in);
    #1;
    frame_tick = 1'b0;
    n_hit += int'(hit);
    n_lvl += int'(level_up);
    n_rsp += int'(respawn);
  endtask

  task automatic idle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic frog_at(input int l, input int r, input int t, input int b);
    frogL = 10'(l); frogR = 10'(r); frogT = 9'(t); frogB = 9'(b);
  endtask

  task automatic clr_cnt();
    n_hit = 0; n_lvl = 0; n_rsp = 0;
  endtask

  initial begin
    reset_in = 1'b1;
    frame_tick = 1'b0;
    frog_at_goal = 1'b0;
    carL = 10'd20; carR = 10'd80; carT = 9'd110; carB = 9'd150;
    frog_at(300, 340, 400, 440);
    idle(); idle();
    @(negedge clk_in);
    reset_in = 1'b0;

    // Reset state
    check("rst_lives", lives, 3);
    check("rst_level", level, 0);
    check("rst_hit", hit, 0);
    check("rst_game_over", game_over, 0);
    check("rst_frozen", frozen, 0);

    // Disjoint boxes
    clr_cnt();
    for (int i = 0; i < 10; i++) tick();
    check("disj_pulses", n_hit + n_lvl + n_rsp, 0);
    check("disj_lives", lives, 3);

    // Touching edge is not overlap
    frog_at(80, 120, 110, 150);
    clr_cnt();
    for (int i = 0; i < 5; i++) tick();
    check("touch_hit", n_hit, 0);

    // One pixel of overlap confirmed over two ticks
    frog_at(79, 119, 110, 150);
    tick();
    check("ovl1_hit", hit, 0);
    tick();
    check("ovl2_hit", hit, 1);
    check("ovl2_lives", lives, 2);
    check("ovl2_frozen", frozen, 1);
    idle();
    check("hit_one_cycle", hit, 0);

    // Hold: overlap persists, respawn after third tick
    tick();
    check("hold1_rsp", respawn, 0);
    tick();
    check("hold2_rsp", respawn, 0);
    check("hold2_lives", lives, 2);
    tick();
    check("hold3_rsp", respawn, 1);
    check("hold3_frozen", frozen, 0);
    check("hold3_lives", lives, 2);
    idle();
    check("rsp_one_cycle", respawn, 0);

    // Confirmation broken by a non-overlapping tick
    clr_cnt();
    tick();
    frog_at(300, 340, 400, 440);
    tick();
    frog_at(79, 119, 110, 150);
    tick();
    check("break_hit", n_hit, 0);
    frog_at(300, 340, 400, 440);
    tick();

    // Goal on four ticks, level saturates at 2
    clr_cnt();
    frog_at_goal = 1'b1;
    tick(); check("goal1_level", level, 1);
    tick(); check("goal2_level", level, 2);
    tick(); check("goal3_level", level, 2);
    tick(); check("goal4_level", level, 2);
    check("goal_lvlup_cnt", n_lvl, 4);
    check("goal_rsp_cnt", n_rsp, 4);
    check("goal_lives", lives, 2);

    // Goal on the confirming tick: hit only
    frog_at_goal = 1'b0;
    frog_at(79, 119, 110, 150);
    tick();
    frog_at_goal = 1'b1;
    tick();
    check("hg_hit", hit, 1);
    check("hg_lvlup", level_up, 0);
    check("hg_rsp", respawn, 0);
    check("hg_lives", lives, 1);
    check("hg_level", level, 2);
    frog_at_goal = 1'b0;
    frog_at(300, 340, 400, 440);
    tick(); tick(); tick();
    check("hg_hold_rsp", respawn, 1);

    // Final hit and game over
    frog_at(79, 119, 110, 150);
    tick(); tick();
    check("go_hit", hit, 1);
    check("go_lives", lives, 0);
    check("go_game_over", game_over, 1);
    check("go_frozen", frozen, 1);
    check("go_rsp", respawn, 0);
    clr_cnt();
    frog_at_goal = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("over_pulses", n_hit + n_lvl + n_rsp, 0);
    check("over_lives", lives, 0);
    check("over_sticky", game_over, 1);
    frog_at_goal = 1'b0;

    // Reset for one edge mid-OVER
    @(negedge clk_in);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    check("rst2_lives", lives, 3);
    check("rst2_level", level, 0);
    check("rst2_game_over", game_over, 0);
    check("rst2_frozen", frozen, 0);
    check("rst2_rsp", respawn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_collision_monitor
`default_nettype wire

// File: doc/collision_monitor.md
# collision_monitor

Game-state consumer of the car/frog bounding-box interface. Samples the car box from each obstacle and the frog box once per frame, and confirms overlap over consecutive frames. Owns the lives counter, level counter, hit freeze and game-over latch. Drives `level` back to the car blocks and `respawn` to the frog and car blocks.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives after reset (1..3).
- `CONFIRM`, 2: consecutive overlapping frame samples required to declare a hit (1..7).
- `HOLD_FRAMES`, 30: frame ticks spent frozen after a hit (1..63).
- `MAX_LEVEL`, 2: level saturation value.

Ports (clock and reset first):
- `clk_in`, in, 1: system clock; the only clock.
- `reset_in`, in, 1: synchronous reset, active-high.
- `frame_tick`, in, 1: one-cycle pulse; box coordinates are stable during it.
- `carL`, `carR`, in, 10: car box X edges.
- `carT`, `carB`, in, 9: car box Y edges.
- `frogL`, `frogR`, in, 10: frog box X edges.
- `frogT`, `frogB`, in, 9: frog box Y edges.
- `frog_at_goal`, in, 1: frog has reached the goal row.
- `hit`, out, 1: one-cycle pulse when a collision is confirmed.
- `level_up`, out, 1: one-cycle pulse on goal reached.
- `respawn`, out, 1: one-cycle pulse telling the frog and car blocks to reload start positions.
- `lives`, out, 2: remaining lives.
- `level`, out, 3: current level; feeds the car `level` input.
- `game_over`, out, 1: sticky until reset.
- `frozen`, out, 1: high in HOLD and OVER.

## Operation
- Overlap is strict on both axes: `frogL < carR && carL < frogR && frogT < carB && carT < frogB`. Compares are unsigned at native widths. Touching edges are not overlap.
- All inputs are sampled only on cycles with `frame_tick=1`. Cycles without `frame_tick` change no state except pulse clearing.
- State machine:
  - PLAY, on a tick:
    - Overlap: `conf_cnt` increments. If the incremented value equals `CONFIRM`, pulse `hit`, decrement `lives` and clear `conf_cnt`. Go to OVER if `lives` becomes 0, otherwise go to HOLD with `hold_cnt=0`.
    - No overlap: `conf_cnt` clears to 0.
    - `frog_at_goal` with no hit confirmed this tick: pulse `level_up` and `respawn`, increment `level` saturating at `MAX_LEVEL`, clear `conf_cnt`, stay in PLAY.
  - HOLD, on a tick: increment `hold_cnt`. When the incremented value equals `HOLD_FRAMES`, pulse `respawn` and return to PLAY with `conf_cnt=0`. Overlap and goal are ignored in HOLD.
  - OVER: absorbing. `game_over=1`; no pulses; ignores all inputs until reset.
- Simultaneous events on a tick:
  - Confirmed hit and goal: the hit wins and the goal is dropped.
  - Overlap below `CONFIRM` together with goal: the goal is taken and `conf_cnt` clears.
- Level is preserved across hits. Only reset clears it.

## Timing
- Reset values, applied at the first rising edge with `reset_in=1`:
  - State PLAY.
  - `hit=0`, `level_up=0`, `respawn=0`, `game_over=0`, `frozen=0`.
  - `lives=LIVES_INIT`, `level=0`, `conf_cnt=0`, `hold_cnt=0`.
- Reset mid-HOLD or in OVER returns to the reset state on that edge. No `respawn` pulse is emitted.
- All outputs are registered.
- Pulses are high for exactly the one cycle following the `frame_tick` edge that caused them.
- Latency from `frame_tick` sample to output is 1 cycle for `hit`, `level_up`, `respawn`, `lives`, `level` and `frozen`.
- `game_over` and `frozen` rise on the same cycle as the final `hit`.
- With `CONFIRM=2`, a hit needs overlap at tick n and tick n+1. `hit` rises one cycle after tick n+1.
- From the hit tick, `respawn` follows after exactly `HOLD_FRAMES` further ticks.
- `lives` never underflows. `level` never exceeds `MAX_LEVEL`.

## Structure
- Shared package `frogger_pkg` holds:
  - `X_W=10` and `Y_W=9`.
  - The state enum `{PLAY, HOLD, OVER}`.
  - Screen constants, also used by the car and frog blocks.
- Sub-module `box_overlap` is purely combinational: it takes two boxes and outputs 1-bit `overlap`. It is reused later for goal and log detection.
- Everything else (FSM, counters, pulse registers) lives in `collision_monitor`.

## Test plan
- Reset then disjoint boxes: car L/R 20/80, T/B 110/150; frog 300/340, 400/440. 10 ticks → no pulses, `lives=3`, `level=0`.
- Edge touch: frog L/R 80/120, T/B 110/150 for 5 ticks → no `hit`, since the strict compare excludes touching edges. Frog 79/119 for 2 ticks → `hit` one cycle after the 2nd tick, `lives=2`, `frozen=1`.
- Hold timing: with `HOLD_FRAMES=3`, after a hit → `respawn` one cycle after the 3rd subsequent tick, then `frozen=0`. Overlap during hold causes no decrement.
- Confirm break: overlap on tick, no overlap on next tick, overlap on the tick after → no `hit` (`conf_cnt` was cleared).
- Goal plus saturation: `frog_at_goal` on 4 separate ticks → 4 `level_up` and 4 `respawn` pulses, `level` reads 1, 2, 2, 2. Goal on the same tick as the 2nd confirmed overlap → `hit` only.
- Game over: three confirmed hits → `lives=0` and `game_over=1` on the cycle of the 3rd `hit`. Further overlap or goal → no pulses. `reset_in` held one edge mid-OVER → `lives=3`, `level=0`, `game_over=0`.
